// File: rtl/note_event_player_pkg.sv
// Shared definitions for the note-event list: field map of a stored event,
// default widths and the playback FSM state encoding.
package note_event_player_pkg;

    localparam int TIME_BITS_DEF = 29;
    localparam int NOTE_BITS_DEF = 6;
    localparam int ADDR_BITS_DEF = 10;

    // Longest recording the time counter is expected to cover (5 minutes).
    localparam int unsigned TIME_MAX_US = 300_000_000;

    // Event word is {timestamp, note, is_on}, is_on in the LSB.
    localparam int IS_ON_POS = 0;
    localparam int NOTE_LSB  = 1;

    function automatic int ts_lsb(input int note_bits);
        return NOTE_LSB + note_bits;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ARMED = 3'd3,
        ST_FIRE  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/note_event_player_if.sv
// Event RAM read port: address/enable from the player, data back one cycle later.
interface note_event_player_if
    import note_event_player_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = TIME_BITS_DEF + NOTE_BITS_DEF + 1
);

    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_en;
    logic [DATA_BITS-1:0] rd_data;

    modport master (output rd_addr, output rd_en, input rd_data);
    modport slave  (input rd_addr, input rd_en, output rd_data);

endinterface

// File: rtl/note_event_player_event_unpack.sv
// Combinational slice of a stored event word into timestamp, note and is_on;
// mirrors the recorder's packer through the shared field map.
module note_event_player_event_unpack
    import note_event_player_pkg::*;
#(
    parameter int TIME_BITS = TIME_BITS_DEF,
    parameter int NOTE_BITS = NOTE_BITS_DEF
) (
    input  logic [TIME_BITS+NOTE_BITS:0] ev,
    output logic [TIME_BITS-1:0]         ts,
    output logic [NOTE_BITS-1:0]         note,
    output logic                         is_on
);

    localparam int TS_LSB = ts_lsb(NOTE_BITS);

    assign ts    = ev[TS_LSB +: TIME_BITS];
    assign note  = ev[NOTE_LSB +: NOTE_BITS];
    assign is_on = ev[IS_ON_POS];

endmodule

// File: rtl/note_event_player.sv
// Playback reader: walks the event list in order, holds each event until the
// shared microsecond time reaches its timestamp, then strobes the note out.
module note_event_player
    import note_event_player_pkg::*;
#(
    parameter int TIME_BITS = TIME_BITS_DEF,
    parameter int NOTE_BITS = NOTE_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [ADDR_BITS-1:0] event_count,
    input  logic [TIME_BITS-1:0] time_us,
    note_event_player_if.master  ram,
    output logic                 note_valid,
    output logic [NOTE_BITS-1:0] note_id,
    output logic                 note_on,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    state_t               state;
    logic [ADDR_BITS-1:0] count_r;
    logic [TIME_BITS-1:0] ts_r;
    logic [NOTE_BITS-1:0] note_r;
    logic                 is_on_r;
    logic [TIME_BITS-1:0] last_time;

    logic [TIME_BITS-1:0] ev_ts;
    logic [NOTE_BITS-1:0] ev_note;
    logic                 ev_is_on;
    logic [ADDR_BITS-1:0] addr_inc;
    logic                 time_wrapped;

    note_event_player_event_unpack #(
        .TIME_BITS (TIME_BITS),
        .NOTE_BITS (NOTE_BITS)
    ) u_unpack (
        .ev    (ram.rd_data),
        .ts    (ev_ts),
        .note  (ev_note),
        .is_on (ev_is_on)
    );

    assign addr_inc     = ram.rd_addr + ADDR_BITS'(1);
    assign busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign done         = (state == ST_DONE);
    assign time_wrapped = busy && (time_us < last_time);

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below sees the values from the start of the cycle, not partial updates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            ram.rd_addr <= '0;
            ram.rd_en   <= 1'b0;
            note_valid  <= 1'b0;
            note_id     <= '0;
            note_on     <= 1'b0;
            overrun     <= 1'b0;
            count_r     <= '0;
            ts_r        <= '0;
            note_r      <= '0;
            is_on_r     <= 1'b0;
            last_time   <= '0;
        end else begin
            // Single-cycle pulses drop by default and are raised only on entry.
            ram.rd_en  <= 1'b0;
            note_valid <= 1'b0;
            if (busy) begin
                last_time <= time_us;
            end

            if (stop) begin
                state       <= ST_IDLE;
                ram.rd_addr <= '0;
            end else if (time_wrapped) begin
                overrun <= 1'b1;
                state   <= ST_DONE;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            count_r     <= event_count;
                            ram.rd_addr <= '0;
                            overrun     <= 1'b0;
                            last_time   <= time_us;
                            if (event_count == '0) begin
                                state <= ST_DONE;
                            end else begin
                                state     <= ST_FETCH;
                                ram.rd_en <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: state <= ST_WAIT;
                    ST_WAIT: begin
                        ts_r    <= ev_ts;
                        note_r  <= ev_note;
                        is_on_r <= ev_is_on;
                        state   <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (time_us >= ts_r) begin
                            state      <= ST_FIRE;
                            note_valid <= 1'b1;
                            note_id    <= note_r;
                            note_on    <= is_on_r;
                        end
                    end
                    ST_FIRE: begin
                        ram.rd_addr <= addr_inc;
                        if (addr_inc == count_r) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_FETCH;
                            ram.rd_en <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_event_player.sv
// Self-checking bench for note_event_player: directed sequences, a table of
// single-event boundary cases and randomized lists against a timing model.
module tb_note_event_player;
    import note_event_player_pkg::*;

    localparam int TB = 29;
    localparam int NB = 6;
    localparam int AB = 10;
    localparam int DB = TB + NB + 1;
    localparam int SCHED_LEN = 300;

    typedef struct {
        int          cyc;
        logic [NB-1:0] id;
        logic        on;
    } strobe_t;

    typedef struct {
        logic [TB-1:0] ts;
        logic [NB-1:0] note;
        logic          on;
        logic [TB-1:0] t;
        logic          exp_fire;
        logic [NB-1:0] exp_id;
        logic          exp_on;
    } vec_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AB-1:0] event_count = '0;
    logic [TB-1:0] time_us = '0;
    logic          note_valid;
    logic [NB-1:0] note_id;
    logic          note_on;
    logic          busy;
    logic          done;
    logic          overrun;

    note_event_player_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) ram ();

    note_event_player #(.TIME_BITS(TB), .NOTE_BITS(NB), .ADDR_BITS(AB)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .stop        (stop),
        .event_count (event_count),
        .time_us     (time_us),
        .ram         (ram),
        .note_valid  (note_valid),
        .note_id     (note_id),
        .note_on     (note_on),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Event RAM model: registered read, data valid the cycle after rd_en.
    logic [DB-1:0] mem [0:(1<<AB)-1];
    always @(posedge clk) begin
        if (ram.rd_en) ram.rd_data <= mem[ram.rd_addr];
    end

    int      cyc = 0;
    int      rd_en_cnt = 0;
    strobe_t strobes [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        strobe_t s;
        if (ram.rd_en) rd_en_cnt <= rd_en_cnt + 1;
        if (note_valid) begin
            s.cyc = cyc;
            s.id  = note_id;
            s.on  = note_on;
            strobes.push_back(s);
        end
    end

    int            n_checks = 0;
    int            n_fail = 0;
    logic [TB-1:0] sched [0:SCHED_LEN-1];
    int            run_base;
    int            run_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [DB-1:0] pack(input logic [TB-1:0] ts, input logic [NB-1:0] n, input logic on);
        return {ts, n, on};
    endfunction

    // Pulses start in relative cycle 0 and drives time_us from sched[] each cycle.
    task automatic run_sched(input int n, input int cycles);
        run_base = cyc;
        run_idx  = strobes.size();
        for (int i = 0; i < cycles; i++) begin
            time_us     = sched[i];
            event_count = AB'(n);
            start       = (i == 0);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic check_strobe(input string name, input int k, input int exp_rel, input logic [NB-1:0] exp_id, input logic exp_on);
        strobe_t s;
        if (run_idx + k < strobes.size()) begin
            s = strobes[run_idx + k];
        end else begin
            s.cyc = run_base - 1;
            s.id  = '0;
            s.on  = 1'b0;
        end
        check({name, "_cycle"}, 64'(s.cyc - run_base), 64'(exp_rel));
        check({name, "_id"}, 64'(s.id), 64'(exp_id));
        check({name, "_on"}, 64'(s.on), 64'(exp_on));
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic fill_sched(input logic [TB-1:0] t);
        for (int i = 0; i < SCHED_LEN; i++) sched[i] = t;
    endtask

    vec_t vecs [8];

    initial begin
        int rd_base;
        int s_base;
        int n;
        int e;
        int f;
        int exp_f [6];
        logic [TB-1:0] ets [6];
        logic [NB-1:0] enote [6];
        logic          eon [6];

        vecs[0] = '{ts: 29'd10, note: 6'd7, on: 1'b1, t: 29'd10, exp_fire: 1'b1, exp_id: 6'd7, exp_on: 1'b1};
        vecs[1] = '{ts: 29'd11, note: 6'd9, on: 1'b0, t: 29'd10, exp_fire: 1'b0, exp_id: 6'd7, exp_on: 1'b1};
        vecs[2] = '{ts: 29'd0, note: 6'd63, on: 1'b0, t: 29'd0, exp_fire: 1'b1, exp_id: 6'd63, exp_on: 1'b0};
        vecs[3] = '{ts: {TB{1'b1}}, note: 6'd1, on: 1'b1, t: {TB{1'b1}}, exp_fire: 1'b1, exp_id: 6'd1, exp_on: 1'b1};
        vecs[4] = '{ts: {TB{1'b1}}, note: 6'd2, on: 1'b0, t: {{(TB-1){1'b1}}, 1'b0}, exp_fire: 1'b0, exp_id: 6'd1, exp_on: 1'b1};
        vecs[5] = '{ts: TB'(TIME_MAX_US), note: 6'd33, on: 1'b1, t: TB'(TIME_MAX_US), exp_fire: 1'b1, exp_id: 6'd33, exp_on: 1'b1};
        vecs[6] = '{ts: TB'(TIME_MAX_US - 1), note: 6'd0, on: 1'b0, t: TB'(TIME_MAX_US), exp_fire: 1'b1, exp_id: 6'd0, exp_on: 1'b0};
        vecs[7] = '{ts: 29'h1000_0000, note: 6'd5, on: 1'b1, t: 29'h0FFF_FFFF, exp_fire: 1'b0, exp_id: 6'd0, exp_on: 1'b0};

        // Reset held with start high: everything quiet.
        resetn = 1'b0;
        start  = 1'b1;
        tick(3);
        check("rst_rd_en", 64'(ram.rd_en), 64'd0);
        check("rst_rd_addr", 64'(ram.rd_addr), 64'd0);
        check("rst_note_valid", 64'(note_valid), 64'd0);
        check("rst_note", 64'({note_id, note_on}), 64'd0);
        check("rst_flags", 64'({busy, done, overrun}), 64'd0);
        start  = 1'b0;
        resetn = 1'b1;
        tick(3);
        check("post_rst_idle", 64'({busy, done}), 64'd0);
        check("post_rst_no_read", 64'(rd_en_cnt), 64'd0);

        // Basic play against a ramping clock.
        mem[0] = pack(29'd10, 6'd5, 1'b1);
        mem[1] = pack(29'd25, 6'd5, 1'b0);
        for (int i = 0; i < SCHED_LEN; i++) sched[i] = TB'(i);
        run_sched(2, 40);
        check("basic_count", 64'(strobes.size() - run_idx), 64'd2);
        check_strobe("basic_s0", 0, 11, 6'd5, 1'b1);
        check_strobe("basic_s1", 1, 26, 6'd5, 1'b0);
        check("basic_done_busy", 64'({done, busy}), 64'b10);

        // Late events play back-to-back at minimum spacing.
        mem[0] = pack(29'd0, 6'd10, 1'b1);
        mem[1] = pack(29'd50, 6'd11, 1'b0);
        mem[2] = pack(29'd99, 6'd12, 1'b1);
        fill_sched(29'd100);
        rd_base = rd_en_cnt;
        run_sched(3, 25);
        check("late_count", 64'(strobes.size() - run_idx), 64'd3);
        check_strobe("late_s0", 0, 4, 6'd10, 1'b1);
        check_strobe("late_s1", 1, 8, 6'd11, 1'b0);
        check_strobe("late_s2", 2, 12, 6'd12, 1'b1);
        check("late_reads", 64'(rd_en_cnt - rd_base), 64'd3);
        check("late_done", 64'(done), 64'd1);

        // Empty list.
        do_stop();
        check("stop_from_done", 64'({done, busy}), 64'd0);
        fill_sched(29'd0);
        rd_base = rd_en_cnt;
        run_sched(0, 2);
        check("empty_done", 64'({done, busy}), 64'b10);
        check("empty_no_read", 64'(rd_en_cnt - rd_base), 64'd0);
        check("empty_no_strobe", 64'(strobes.size() - run_idx), 64'd0);

        // Time wrap while waiting for an event.
        mem[0] = pack(29'd299_999_990, 6'd4, 1'b1);
        for (int i = 0; i < SCHED_LEN; i++) sched[i] = (i < 8) ? 29'd299_999_980 : 29'd0;
        run_sched(1, 16);
        check("wrap_overrun", 64'(overrun), 64'd1);
        check("wrap_done", 64'(done), 64'd1);
        check("wrap_no_strobe", 64'(strobes.size() - run_idx), 64'd0);
        fill_sched(29'd0);
        run_sched(1, 3);
        check("wrap_restart_clear", 64'(overrun), 64'd0);
        check("wrap_restart_busy", 64'(busy), 64'd1);
        do_stop();

        // Abort on the very cycle the armed event would fire.
        mem[0] = pack(29'd0, 6'd20, 1'b1);
        mem[1] = pack(29'd50, 6'd21, 1'b0);
        fill_sched(29'd0);
        run_sched(2, 12);
        s_base = run_idx;
        check("abort_armed_addr", 64'(ram.rd_addr), 64'd1);
        time_us = 29'd50;
        do_stop();
        check("abort_no_strobe", 64'(note_valid), 64'd0);
        check("abort_idle", 64'({busy, done}), 64'd0);
        check("abort_addr", 64'(ram.rd_addr), 64'd0);
        check("abort_held_note", 64'({note_id, note_on}), 64'({6'd20, 1'b1}));
        tick(2);
        check("abort_strobes", 64'(strobes.size() - s_base), 64'd1);
        fill_sched(29'd50);
        run_sched(2, 14);
        check_strobe("replay_s0", 0, 4, 6'd20, 1'b1);
        check_strobe("replay_s1", 1, 8, 6'd21, 1'b0);

        // Single-event boundary table, time held constant.
        for (int v = 0; v < 8; v++) begin
            do_stop();
            mem[0] = pack(vecs[v].ts, vecs[v].note, vecs[v].on);
            fill_sched(vecs[v].t);
            run_sched(1, 10);
            check($sformatf("vec%0d_fired", v), 64'(strobes.size() - run_idx), 64'(vecs[v].exp_fire));
            check($sformatf("vec%0d_note", v), 64'({note_id, note_on}), 64'({vecs[v].exp_id, vecs[v].exp_on}));
            check($sformatf("vec%0d_done", v), 64'(done), 64'(vecs[v].exp_fire));
        end
        do_stop();

        // Randomized lists: each event fires at the first cycle, no sooner than
        // 4 cycles after the previous strobe (4 after start for the first), whose
        // preceding-cycle time has reached its timestamp.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                ets[k]   = TB'($urandom_range(0, 80));
                enote[k] = NB'($urandom_range(0, 63));
                eon[k]   = 1'($urandom_range(0, 1));
                mem[k]   = pack(ets[k], enote[k], eon[k]);
            end
            sched[0] = TB'($urandom_range(0, 5));
            for (int i = 1; i < SCHED_LEN; i++) sched[i] = sched[i-1] + TB'($urandom_range(1, 2));
            e = 4;
            for (int k = 0; k < n; k++) begin
                f = e;
                while (f < SCHED_LEN && sched[f-1] < ets[k]) f++;
                exp_f[k] = f;
                e = f + 4;
            end
            run_sched(n, SCHED_LEN);
            check($sformatf("rand%0d_count", r), 64'(strobes.size() - run_idx), 64'(n));
            for (int k = 0; k < n; k++) begin
                check_strobe($sformatf("rand%0d_s%0d", r, k), k, exp_f[k], enote[k], eon[k]);
            end
            check($sformatf("rand%0d_done", r), 64'(done), 64'd1);
            do_stop();
        end

        // Reset asserted mid-playback.
        mem[0] = pack(29'd0, 6'd10, 1'b1);
        mem[1] = pack(29'd50, 6'd11, 1'b0);
        mem[2] = pack(29'd99, 6'd12, 1'b1);
        fill_sched(29'd100);
        run_sched(3, 6);
        s_base = strobes.size();
        resetn = 1'b0;
        #1;
        check("midrst_note", 64'({note_id, note_on}), 64'd0);
        check("midrst_flags", 64'({busy, done, overrun, note_valid}), 64'd0);
        check("midrst_addr", 64'({ram.rd_addr, ram.rd_en}), 64'd0);
        tick(3);
        check("midrst_no_strobe", 64'(strobes.size() - s_base), 64'd0);
        resetn = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_event_player.md
Name: note_event_player

Overview:
- Playback-side reader of the recorded note-event list.
- Each event is a timestamp plus a note, written earlier during record using the shared microsecond time counter.
- The block fetches events in order from the event RAM read port, holds each one until the shared microsecond time reaches its timestamp, then emits a one-cycle note strobe.
- It sits between the event RAM and the tone/voice generators, and is driven by the same time counter the recorder uses.

Parameters:
- TIME_BITS, 29, width of microsecond timestamps (5 min = 300,000,000 us).
- NOTE_BITS, 6, note index width.
- ADDR_BITS, 10, event RAM address width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin playback from address 0 (ignored unless IDLE or DONE)
- stop  in  1  level or pulse: abort playback, return to IDLE
- event_count  in  ADDR_BITS  number of valid events; sampled on start
- time_us  in  TIME_BITS  current microsecond count from the shared time counter
- rd_addr  out  ADDR_BITS  event RAM read address
- rd_en  out  1  event RAM read enable
- rd_data  in  TIME_BITS+NOTE_BITS+1  {timestamp, note, is_on}, valid exactly 1 cycle after rd_en
- note_valid  out  1  one-cycle strobe: event fired
- note_id  out  NOTE_BITS  note of fired event, held until next fire
- note_on  out  1  1 = key press, 0 = release, held with note_id
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high while in DONE
- overrun  out  1  sticky: time wrapped before list finished; cleared by start or reset

Behaviour:
- Reset (resetn=0, async) values:
  - state = IDLE; rd_addr = 0; rd_en = 0.
  - note_valid = 0, note_id = 0, note_on = 0.
  - busy = 0, done = 0, overrun = 0.
  - Internal count, timestamp and last-time registers = 0.
- FSM states: IDLE, FETCH, WAIT, ARMED, FIRE, DONE.
- IDLE or DONE + start:
  - latch event_count; rd_addr = 0; clear overrun; capture last_time = time_us.
  - event_count = 0 -> go to DONE next cycle, no read issued; else -> FETCH.
- FETCH: rd_en = 1 for exactly this cycle at rd_addr -> WAIT.
- WAIT: capture rd_data into timestamp/note/is_on registers -> ARMED.
- ARMED: each cycle compare time_us >= timestamp (unsigned, full TIME_BITS).
  - True -> FIRE.
  - Timestamp already in the past fires on the first ARMED cycle, so late events play back-to-back in list order.
- FIRE:
  - note_valid = 1 for one cycle; note_id/note_on updated this cycle; rd_addr increments.
  - If the incremented address == latched count -> DONE, else -> FETCH.
  - Minimum spacing between strobes is 4 cycles.
- Time wrap:
  - Track last_time each cycle while busy.
  - If time_us < last_time, the time counter has wrapped: set overrun = 1 and go to DONE without firing the pending event.
- stop:
  - Has priority over every transition, including FIRE in the same cycle; no strobe is emitted.
  - Next state IDLE; rd_addr = 0; note_id/note_on keep their last values.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- Address arithmetic is ADDR_BITS wide. event_count = 2^ADDR_BITS-1 is the maximum list length; no wrap inside a run.
- A resetn assertion mid-operation returns immediately to reset values. No strobe is emitted while resetn is low.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..DONE);
  - event field widths and bit positions (timestamp MSBs, note, is_on LSB);
  - TIME_MAX_US = 300,000,000.
- One natural sub-module: event_unpack, a combinational slice of rd_data into fields; the same field map is reused by the recorder's packer.
- Everything else stays in one FSM module.

Test Plan:
- Reset: hold resetn=0 with start=1 -> all outputs 0, state IDLE. Release -> still IDLE, no rd_en.
- Basic play: RAM = {(10,note5,on),(25,note5,off)}, event_count=2, time_us ramps from 0 per cycle, start.
  - note_valid when time_us first >= 10 (id 5, on=1), then when >= 25 (id 5, on=0).
  - Then done=1, busy=0, exactly 2 strobes.
- Late events: time_us held at 100, three events at 0/50/99 -> three strobes in address order, 4 cycles apart, then DONE.
- Empty list: event_count=0, start -> done=1 two cycles later, rd_en never asserted.
- Wrap: event at 299,999,990, time_us jumps 299,999,980 -> 0 -> overrun=1, DONE, no strobe. A following start clears overrun.
- Abort: stop asserted in the same cycle ARMED->FIRE would occur -> no note_valid, IDLE next cycle, rd_addr=0. Then start replays from address 0.
